// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for axi_lite_slave_regs.
// The master drives requests and response readies; the slave drives the rest.
interface axi_lite_slave_regs_if #(
  parameter int ALEN = 32,
  parameter int DLEN = 32
);
  logic              awvalid;
  logic              awready;
  logic [ALEN-1:0]   awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DLEN-1:0]   wdata;
  logic [DLEN/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ALEN-1:0]   araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DLEN-1:0]   rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NREGS DLEN-bit registers.
// Define AXIL_SLAVE_STRB_EN to honour wstrb byte lanes on writes.
module axi_lite_slave_regs #(
  parameter int ALEN  = 32,
  parameter int DLEN  = 32,
  parameter int NREGS = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_lite_slave_regs_if.slave  s_axi,
  output logic [NREGS*DLEN-1:0] regs_o,
  output logic [NREGS-1:0]      wr_pulse_o
);
  localparam int SB  = DLEN / 8;
  localparam int OFF = $clog2(SB);
  localparam int NB  = $clog2(NREGS);
  localparam int HI  = OFF + NB;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_D,
    W_WAIT_A,
    W_RESP
  } wst_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rdst_t;

  wst_t             r_wst;
  wst_t             w_wst_nxt;
  rdst_t            r_rst;
  rdst_t            w_rst_nxt;
  logic             r_live;
  logic [DLEN-1:0]  r_regs [NREGS];
  logic [NB-1:0]    r_aw_idx;
  logic             r_aw_ok;
  logic [DLEN-1:0]  r_wdata;
  logic [NREGS-1:0] r_wr_pulse;
  logic [1:0]       r_bresp;
  logic [1:0]       r_rresp;
  logic [DLEN-1:0]  r_rdata;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_wr_go;
  logic [NB-1:0]    w_aw_idx;
  logic [NB-1:0]    w_ar_idx;
  logic [NB-1:0]    w_cidx;
  logic             w_aw_ok;
  logic             w_ar_ok;
  logic             w_cok;
  logic [DLEN-1:0]  w_cdata;
  logic [DLEN-1:0]  w_new;
  logic             w_unused;

  assign s_axi.awready = r_live &&
    (r_wst == W_IDLE || r_wst == W_WAIT_A);
  assign s_axi.wready  = r_live &&
    (r_wst == W_IDLE || r_wst == W_WAIT_D);
  assign s_axi.bvalid  = (r_wst == W_RESP);
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_live && (r_rst == R_IDLE);
  assign s_axi.rvalid  = (r_rst == R_DATA);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  assign w_aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_w_hs  = s_axi.wvalid  && s_axi.wready;
  assign w_b_hs  = s_axi.bvalid  && s_axi.bready;
  assign w_ar_hs = s_axi.arvalid && s_axi.arready;
  assign w_r_hs  = s_axi.rvalid  && s_axi.rready;

  assign w_aw_idx = s_axi.awaddr[OFF +: NB];
  assign w_ar_idx = s_axi.araddr[OFF +: NB];
  assign w_aw_ok  = ~|s_axi.awaddr[ALEN-1:HI];
  assign w_ar_ok  = ~|s_axi.araddr[ALEN-1:HI];

  // The commit takes whichever half arrived earlier from its holding reg.
  assign w_cidx  = (r_wst == W_WAIT_D) ? r_aw_idx : w_aw_idx;
  assign w_cok   = (r_wst == W_WAIT_D) ? r_aw_ok : w_aw_ok;
  assign w_cdata = (r_wst == W_WAIT_A) ? r_wdata : s_axi.wdata;

`ifdef AXIL_SLAVE_STRB_EN
  logic [SB-1:0] r_wstrb;
  logic [SB-1:0] w_cstrb;

  assign w_cstrb = (r_wst == W_WAIT_A) ? r_wstrb : s_axi.wstrb;

  // Merge enabled byte lanes into the current register value.
  always_comb begin
    w_new = r_regs[w_cidx];
    for (int b = 0; b < SB; b++) begin
      if (w_cstrb[b]) w_new[b*8 +: 8] = w_cdata[b*8 +: 8];
    end
  end

  // Hold the strobes of an early W beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    r_wstrb <= '0;
    else if (w_w_hs) r_wstrb <= s_axi.wstrb;
  end

  assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                      s_axi.awaddr[OFF-1:0],
                      s_axi.araddr[OFF-1:0]};
`else
  assign w_new    = w_cdata;
  assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                      s_axi.awaddr[OFF-1:0],
                      s_axi.araddr[OFF-1:0],
                      s_axi.wstrb};
`endif

  // State registers; readies stay low until the first edge after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wst  <= W_IDLE;
      r_rst  <= R_IDLE;
      r_live <= 1'b0;
    end else begin
      r_wst  <= w_wst_nxt;
      r_rst  <= w_rst_nxt;
      r_live <= 1'b1;
    end
  end

  // Write FSM: pair AW and W in either order, then hold the response.
  always_comb begin
    w_wst_nxt = r_wst;
    w_wr_go   = 1'b0;
    unique case (r_wst)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wst_nxt = W_RESP;
          w_wr_go   = 1'b1;
        end else if (w_aw_hs) begin
          w_wst_nxt = W_WAIT_D;
        end else if (w_w_hs) begin
          w_wst_nxt = W_WAIT_A;
        end
      end
      W_WAIT_D: begin
        if (w_w_hs) begin
          w_wst_nxt = W_RESP;
          w_wr_go   = 1'b1;
        end
      end
      W_WAIT_A: begin
        if (w_aw_hs) begin
          w_wst_nxt = W_RESP;
          w_wr_go   = 1'b1;
        end
      end
      W_RESP: begin
        if (w_b_hs) w_wst_nxt = W_IDLE;
      end
    endcase
  end

  // Read FSM: one outstanding read, data held until accepted.
  always_comb begin
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE: if (w_ar_hs) w_rst_nxt = R_DATA;
      R_DATA: if (w_r_hs)  w_rst_nxt = R_IDLE;
    endcase
  end

  // Capture the early half of a split write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_idx <= '0;
      r_aw_ok  <= 1'b0;
      r_wdata  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_idx <= w_aw_idx;
        r_aw_ok  <= w_aw_ok;
      end
      if (w_w_hs) r_wdata <= s_axi.wdata;
    end
  end

  // Register file update, write pulse and write response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
      r_bresp    <= 2'b00;
    end else begin
      r_wr_pulse <= '0;
      if (w_wr_go) begin
        r_bresp <= w_cok ? 2'b00 : 2'b10;
        if (w_cok) begin
          r_regs[w_cidx]     <= w_new;
          r_wr_pulse[w_cidx] <= 1'b1;
        end
      end
    end
  end

  // Read data is sampled at AR acceptance, before any same-cycle write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (w_ar_hs) begin
      r_rdata <= w_ar_ok ? r_regs[w_ar_idx] : '0;
      r_rresp <= w_ar_ok ? 2'b00 : 2'b10;
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    assign regs_o[gi*DLEN +: DLEN] = r_regs[gi];
  end

  assign wr_pulse_o = r_wr_pulse;

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 The block SHALL have parameter ALEN, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter DLEN, default 32, meaning data width in bits; legal values are 32 and 64.
REQ-003 The block SHALL have parameter NREGS, default 16, meaning the number of DLEN-bit registers; it is a power of two, at least 2.
REQ-004 aclk  input  1  clock; all logic is on the rising edge.
REQ-005 aresetn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 awvalid/awready  input/output  1/1  write-address handshake; awaddr  input  ALEN; awprot  input  3, ignored.
REQ-007 wvalid/wready  input/output  1/1  write-data handshake; wdata  input  DLEN; wstrb  input  DLEN/8  byte strobes.
REQ-008 bvalid/bready  output/input  1/1  write-response handshake; bresp  output  2.
REQ-009 arvalid/arready  input/output  1/1  read-address handshake; araddr  input  ALEN; arprot  input  3, ignored.
REQ-010 rvalid/rready  output/input  1/1  read-data handshake; rdata  output  DLEN; rresp  output  2.
REQ-011 regs_o  output  NREGS*DLEN  current register contents, with register i at bits [i*DLEN +: DLEN].
REQ-012 wr_pulse_o  output  NREGS  one-cycle strobe per register, high in the cycle after that register is written.

Function
REQ-013 Address decode SHALL use word index = addr[log2(DLEN/8) +: log2(NREGS)]; the low log2(DLEN/8) bits SHALL be ignored; any set bit above the index SHALL make the address out of range.
REQ-014 The write FSM SHALL have the states W_IDLE (awready=1, wready=1), W_WAIT_D (awready=0, wready=1), W_WAIT_A (awready=1, wready=0) and W_RESP (awready=0, wready=0, bvalid=1).
REQ-015 From W_IDLE, an AW-only handshake SHALL go to W_WAIT_D, a W-only handshake to W_WAIT_A, and both handshakes in the same cycle directly to W_RESP; the captured address or data SHALL be held in the WAIT states.
REQ-016 In the cycle the second handshake (or the joint handshake) completes (cycle N), an in-range register SHALL update at the end of N; bvalid and wr_pulse_o SHALL be high in N+1.
REQ-017 W_RESP SHALL hold bvalid and bresp stable until bvalid&&bready, then return to W_IDLE; the next AW/W SHALL be accepted no earlier than the following cycle.
REQ-018 bresp SHALL be 2'b00 (OKAY) for an in-range write; for an out-of-range write it SHALL be 2'b10 (SLVERR), with no register modified and no wr_pulse_o.
REQ-019 The read FSM SHALL have the states R_IDLE (arready=1) and R_DATA (arready=0, rvalid=1); an AR handshake in cycle N SHALL produce rvalid in N+1; the state SHALL return to R_IDLE on rvalid&&rready.
REQ-020 rdata and rresp SHALL be registered at AR acceptance and held stable while rvalid=1; an out-of-range read SHALL return rdata=0 and rresp=2'b10.
REQ-021 Read and write FSMs SHALL be independent; if a read is accepted in the same cycle N as a write to the same register takes effect, rdata SHALL be the pre-write value.
REQ-022 Valid outputs SHALL never depend combinationally on ready inputs.

Reset
REQ-023 While aresetn=0: all registers, regs_o and wr_pulse_o SHALL be 0; awready, wready, arready, bvalid and rvalid SHALL be 0; bresp, rresp and rdata SHALL be 0; both FSMs SHALL be in their idle states.
REQ-024 awready, wready and arready SHALL rise at the first rising aclk edge after aresetn is released.
REQ-025 Reset asserted mid-transaction SHALL abort it with no register update and no response issued after release.

Configuration
REQ-026 With AXIL_SLAVE_STRB_EN defined, a write SHALL update only the bytes whose wstrb bit is 1; wstrb=0 SHALL still give OKAY and a wr_pulse_o.
REQ-027 Without AXIL_SLAVE_STRB_EN, wstrb SHALL be ignored and every in-range write SHALL replace the full word.

Verification
REQ-028 Joint AW+W to 0x08 with data 0xDEADBEEF and wstrb=0xF, bready=1: bvalid one cycle later with bresp=00; regs_o word 2 = 0xDEADBEEF; wr_pulse_o[2] pulses once.
REQ-029 W (0x12345678) three cycles before AW (0x04): wready drops after the W handshake; on AW, word 1 = 0x12345678 and bresp=00.
REQ-030 Write to 0x40 with NREGS=16: bresp=10, regs_o unchanged. Read from 0x40: rdata=0, rresp=10.
REQ-031 Read from 0x08 with rready held low for 4 cycles: rvalid and rdata=0xDEADBEEF stable for all 4 cycles, and arready=0 until the handshake.
REQ-032 With the macro defined, word 3 = 0xFFFFFFFF, then write 0x00000000 with wstrb=0x2: word 3 = 0xFFFF00FF. Without the macro: word 3 = 0x00000000.
REQ-033 Assert aresetn low in W_WAIT_D: after release, all regs_o = 0, bvalid stays 0, and the readies rise on the first edge.
